// File: rtl/rv_result_fifo.sv
// rv_result_fifo: result buffer between the pipeline controller and the downstream consumer.
// Latency: a push at edge N is visible on out_valid/out_data right after edge N (first-word fall-through).
// Backpressure: in_ready = !full from registered state only; a push while full is dropped and sets sticky overflow.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      synchronous active-low reset
//   in_valid   result available from the controller
//   in_data    result payload
//   in_ready   buffer can take a result this cycle (feeds controller ready_in)
//   out_valid  head entry available
//   out_data   head entry payload
//   out_ready  consumer accepts the head entry
//   count      occupied entries, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
//   overflow   sticky: a result was offered while the buffer was full
module rv_result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;

  logic push;
  logic pop;
  logic push_refused;

  // Flags come from the count register only, so nothing on the out side
  // reaches in_ready combinationally: a pop while full does not admit a push
  // in the same cycle.
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr];
  assign count     = count_q;
  assign overflow  = overflow_q;

  assign push         = in_valid && in_ready;
  assign pop          = out_valid && out_ready;
  assign push_refused = in_valid && !in_ready;

  // Storage. Entries are cleared on reset so out_data reads 0 afterwards.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Occupancy: push and pop together leave the count unchanged.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky until reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else if (push_refused) begin
      overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rv_result_fifo.sv
// Testbench for rv_result_fifo: directed stimulus, queue scoreboard, decoupled output monitor.
module tb_rv_result_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready = 1'b0;
  logic [2:0]       count;
  logic             full;
  logic             empty;
  logic             overflow;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  always #5 clk = ~clk;

  rv_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic status(input string tag, input int exp_count, input logic exp_ovf);
    chk({tag, ".count"},     32'(count),     32'(exp_count));
    chk({tag, ".full"},      32'(full),      32'(exp_count == DEPTH));
    chk({tag, ".empty"},     32'(empty),     32'(exp_count == 0));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(exp_count != DEPTH));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_count != 0));
    chk({tag, ".overflow"},  32'(overflow),  32'(exp_ovf));
  endtask

  // Monitor: a pop happens at the next rising edge whenever these hold now.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_data: unexpected output 0x%0h with empty scoreboard at %0t", out_data, $time);
      end else begin
        chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic drain(input string tag);
    out_ready = 1'b1;
    for (int k = 0; k < 20 && !empty; k++) step();
    out_ready = 1'b0;
    chk({tag, ".drained"}, 32'(empty), 32'(1));
    chk({tag, ".queue"},   32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    // Reset and idle
    reset = 1'b0;
    repeat (2) step();
    status("reset", 0, 1'b0);
    chk("reset.out_data", 32'(out_data), 32'(0));
    reset = 1'b1;
    repeat (2) step();
    status("idle", 0, 1'b0);

    // Fill without consuming
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hA0 + 32'(i);
      exp_q.push_back(32'hA0 + 32'(i));
      step();
      chk("fill.count", 32'(count), 32'(i + 1));
      chk("fill.out_valid", 32'(out_valid), 32'(1));
    end
    in_valid = 1'b0;
    status("full", 4, 1'b0);
    chk("full.head", 32'(out_data), 32'hA0);

    // Overflow attempt: dropped, sticky flag
    in_valid = 1'b1;
    in_data  = 32'hFF;
    step();
    in_valid = 1'b0;
    status("ovf", 4, 1'b1);
    drain("drain1");
    status("after_drain1", 0, 1'b1);

    // Streaming with wrap; count sits at 1 after the first push
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_data = 32'(i);
      exp_q.push_back(32'(i));
      step();
      chk("stream.count", 32'(count), 32'(1));
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    status("stream_end", 0, 1'b1);
    chk("stream.queue", 32'(exp_q.size()), 32'(0));

    // Clean slate so the refused push visibly sets overflow
    reset = 1'b0;
    step();
    reset = 1'b1;
    status("reset2", 0, 1'b0);

    // Full with simultaneous pop: pop only, push refused
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hB0 + 32'(i);
      exp_q.push_back(32'hB0 + 32'(i));
      step();
    end
    status("full2", 4, 1'b0);
    in_valid  = 1'b1;
    in_data   = 32'hCC;
    out_ready = 1'b1;
    step();
    status("full_pop", 3, 1'b1);
    in_valid  = 1'b1;
    in_data   = 32'hC1;
    exp_q.push_back(32'hC1);
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    status("push_after", 4, 1'b1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    status("pre_reset", 3, 1'b1);

    // Reset mid-operation, with push and pop offered in the same cycle
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hEE;
    out_ready = 1'b1;
    exp_q.delete();
    step();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    status("mid_reset", 0, 1'b0);
    chk("mid_reset.out_data", 32'(out_data), 32'(0));
    in_valid = 1'b1;
    in_data  = 32'h55;
    exp_q.push_back(32'h55);
    step();
    in_valid = 1'b0;
    chk("post_reset.head", 32'(out_data), 32'h55);
    status("post_reset", 1, 1'b0);
    drain("drain_final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
